// File: rtl/spike_rate_decoder.sv
// Two-channel spike rate decoder: counts rising edges on each spike line over a
// fixed power-of-two window and hands the per-window counts out over valid/ready.
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       spike_in,
  output logic [CNT_W-1:0] rate0,
  output logic [CNT_W-1:0] rate1,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic             win_busy
);

  // Handshake: a result moves on any cycle where rate_valid and rate_ready are
  // both high; rate0/rate1 stay frozen while rate_valid is high and unconsumed.

  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WINDOW_LOG2-1:0] WIN_ONE  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;

  logic [1:0]             spike_q;
  logic [1:0]             edge_det;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]       acc0;
  logic [CNT_W-1:0]       acc1;
  logic [CNT_W-1:0]       next0;
  logic [CNT_W-1:0]       next1;
  logic                   terminal;
  logic                   accept;

  assign edge_det = spike_in & ~spike_q;

  // Saturating sums include the current cycle's edge so the terminal edge lands in the result.
  assign next0 = (acc0 == CNT_MAX) ? acc0 : acc0 + {{(CNT_W-1){1'b0}}, edge_det[0]};
  assign next1 = (acc1 == CNT_MAX) ? acc1 : acc1 + {{(CNT_W-1){1'b0}}, edge_det[1]};

  assign terminal = en && (win_cnt == WIN_LAST);
  assign accept   = !rate_valid || rate_ready;
  assign win_busy = (win_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q    <= 2'b00;
      win_cnt    <= '0;
      acc0       <= '0;
      acc1       <= '0;
      rate0      <= '0;
      rate1      <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      spike_q <= spike_in;

      if (en) begin
        win_cnt <= win_cnt + WIN_ONE;
        if (terminal) begin
          acc0 <= '0;
          acc1 <= '0;
        end else begin
          acc0 <= next0;
          acc1 <= next1;
        end
      end

      // A fresh result wins over the clearing transfer in the same cycle.
      if (terminal && accept) begin
        rate0      <= next0;
        rate1      <= next1;
        rate_valid <= 1'b1;
      end else begin
        if (terminal) begin
          overrun <= 1'b1;
        end
        if (rate_valid && rate_ready) begin
          rate_valid <= 1'b0;
        end
      end
    end
  end

endmodule
